// File: rtl/tick_timer.sv
// Tick-driven countdown timer with one-shot / periodic auto-reload and a one-cycle expire pulse.
// Optional pause port and PAUSED state are built in when TICK_TIMER_PAUSE_EN is defined.
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             expire,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

`ifdef TICK_TIMER_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_load,  w_load_nxt;
  logic             r_periodic, w_periodic_nxt;
  logic             r_expire, w_expire_nxt;
  logic             w_start_ok;

  assign w_start_ok = start && (load_val != ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= ZERO;
      r_load     <= ZERO;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_load     <= w_load_nxt;
      r_periodic <= w_periodic_nxt;
      r_expire   <= w_expire_nxt;
    end
  end

  // Priority: stop > valid start > per-state tick/pause handling.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_load_nxt     = r_load;
    w_periodic_nxt = r_periodic;
    w_expire_nxt   = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
      w_count_nxt = ZERO;
    end else if (w_start_ok) begin
      w_state_nxt    = RUN;
      w_count_nxt    = load_val;
      w_load_nxt     = load_val;
      w_periodic_nxt = periodic;
    end else begin
      case (r_state)
        RUN: begin
`ifdef TICK_TIMER_PAUSE_EN
          if (pause) begin
            // A tick on the pause-entry edge is dropped.
            w_state_nxt = PAUSED;
          end else
`endif
          if (tick) begin
            if (r_count > ONE) begin
              w_count_nxt = r_count - ONE;
            end else if (r_count == ONE) begin
              w_expire_nxt = 1'b1;
              if (r_periodic) begin
                w_count_nxt = r_load;
              end else begin
                w_count_nxt = ZERO;
                w_state_nxt = IDLE;
              end
            end
          end
        end
`ifdef TICK_TIMER_PAUSE_EN
        PAUSED: begin
          if (!pause) w_state_nxt = RUN;
        end
`endif
        default: ;
      endcase
    end
  end

  assign expire = r_expire;
  assign busy   = (r_state != IDLE);
  assign count  = r_count;

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of load value and counter (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-cycle enable pulse from the upstream pulse generator.
REQ-005 SHALL have port load_val  input  WIDTH  countdown start value, in ticks.
REQ-006 SHALL have port start  input  1  start/restart request, sampled every cycle.
REQ-007 SHALL have port stop  input  1  abort request, sampled every cycle.
REQ-008 SHALL have port periodic  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled at start.
REQ-009 SHALL have port expire  output  1  one-cycle registered pulse on expiry.
REQ-010 SHALL have port busy  output  1  high while state is not IDLE.
REQ-011 SHALL have port count  output  WIDTH  current remaining ticks, registered.

Function
REQ-012 SHALL implement states IDLE and RUN (plus PAUSED per REQ-025); busy = (state != IDLE).
REQ-013 SHALL, on start=1 with load_val != 0 and stop=0 in any state, latch load_val and periodic, set count=load_val and enter RUN at the next edge (busy high 1 cycle after start).
REQ-014 SHALL ignore start when load_val == 0: state, count and latched values unchanged, no expire.
REQ-015 SHALL give stop priority over start and tick: next edge state=IDLE, count=0, expire=0.
REQ-016 SHALL, in RUN with tick=1 and count > 1, decrement count by exactly 1.
REQ-017 SHALL, in RUN with tick=1 and count == 1, assert expire for exactly the next cycle; one-shot: count=0, state=IDLE; periodic: count=latched load value, stay RUN.
REQ-018 SHALL give a valid start priority over a coincident tick in RUN (restart; no decrement, no expire).
REQ-019 SHALL ignore tick in IDLE and PAUSED.
REQ-020 SHALL use only the latched load value for reloads; load_val changes during RUN have no effect until the next start.
REQ-021 SHALL never wrap count below 0 or produce expire outside REQ-017.
REQ-022 SHALL keep expire low in every cycle not following a qualifying tick, including back-to-back ticks (load value 1 periodic gives expire after every tick).

Reset
REQ-023 SHALL, when reset=1 at a rising edge, force state=IDLE, count=0, expire=0, busy=0, latched load value=0, latched periodic=0, overriding all other inputs.
REQ-024 SHALL treat reset asserted mid-countdown identically to REQ-023; a pending expire is discarded.

Configuration
REQ-025 SHALL, when macro TICK_TIMER_PAUSE_EN is defined, add port pause  input  1 and state PAUSED: RUN with pause=1 -> PAUSED (count frozen, busy=1); PAUSED with pause=0 -> RUN; stop from PAUSED -> IDLE; start from PAUSED -> RUN with reload; a tick coincident with the pause-entry edge is ignored.
REQ-026 SHALL, when TICK_TIMER_PAUSE_EN is undefined, omit the pause port and PAUSED state entirely, with behaviour otherwise identical.

Verification
REQ-027 SHALL cover one-shot: load_val=3, periodic=0, start, then 3 ticks -> count 3,2,1,0; expire high exactly 1 cycle after 3rd tick; busy low thereafter.
REQ-028 SHALL cover periodic: load_val=2, periodic=1, 6 ticks -> expire after ticks 2, 4 and 6; count reloads to 2; busy stays 1.
REQ-029 SHALL cover priority: start+stop same cycle -> IDLE, count 0; start+tick in RUN at count=1 -> count=load_val, no expire.
REQ-030 SHALL cover boundaries: start with load_val=0 -> no state change; WIDTH=16, load_val=16'hFFFF -> first tick gives count 16'hFFFE.
REQ-031 SHALL cover reset at count=1 coincident with tick -> count 0, no expire, busy 0.
REQ-032 SHALL cover, with TICK_TIMER_PAUSE_EN, load_val=4, 1 tick, pause=1 for 5 ticks, pause=0, 3 ticks -> count frozen at 3 during pause, expire after final tick.
